// File: rtl/acs_butterfly.sv
// Viterbi ACS butterfly: updates path metrics of states j and j+32 from predecessors 2j/2j+1.
// One-cycle latency, no backpressure: each step pulse yields one result, dec_valid the cycle after.
module acs_butterfly #(
    parameter int PM_W      = 8,
    parameter int INIT_ZERO = 0,
    parameter int INIT_MAX  = 63
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            step,
    input  logic            norm,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    input  logic [PM_W-1:0] pm_in_a,
    input  logic [PM_W-1:0] pm_in_b,
    output logic [PM_W-1:0] pm_lo,
    output logic [PM_W-1:0] pm_hi,
    output logic            dec_lo,
    output logic            dec_hi,
    output logic            dec_valid
);

    localparam logic [PM_W-1:0] INIT_HI = PM_W'(INIT_MAX);
    localparam logic [PM_W-1:0] INIT_LO = (INIT_ZERO != 0) ? '0 : INIT_HI;
    localparam logic [PM_W-1:0] MSB_CLR = {1'b0, {(PM_W-1){1'b1}}};

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                                 input logic [1:0]      bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
        return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
    endfunction

    logic [PM_W-1:0] cand_a_lo, cand_b_lo, cand_a_hi, cand_b_hi;
    logic [PM_W-1:0] sel_lo, sel_hi;
    logic            sel_dec_lo, sel_dec_hi;

    // Trellis symmetry: the hi successor sees the branch metrics swapped.
    always_comb begin
        cand_a_lo  = sat_add(pm_in_a, bm0);
        cand_b_lo  = sat_add(pm_in_b, bm1);
        cand_a_hi  = sat_add(pm_in_a, bm1);
        cand_b_hi  = sat_add(pm_in_b, bm0);
        sel_dec_lo = cand_b_lo < cand_a_lo;
        sel_dec_hi = cand_b_hi < cand_a_hi;
        sel_lo     = sel_dec_lo ? cand_b_lo : cand_a_lo;
        sel_hi     = sel_dec_hi ? cand_b_hi : cand_a_hi;
        // Clearing the MSB leaves an already-small metric untouched.
        if (norm) begin
            sel_lo = sel_lo & MSB_CLR;
            sel_hi = sel_hi & MSB_CLR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm_lo     <= INIT_LO;
            pm_hi     <= INIT_HI;
            dec_lo    <= 1'b0;
            dec_hi    <= 1'b0;
            dec_valid <= 1'b0;
        end else if (init) begin
            pm_lo     <= INIT_LO;
            pm_hi     <= INIT_HI;
            dec_lo    <= 1'b0;
            dec_hi    <= 1'b0;
            dec_valid <= 1'b0;
        end else if (step) begin
            pm_lo     <= sel_lo;
            pm_hi     <= sel_hi;
            dec_lo    <= sel_dec_lo;
            dec_hi    <= sel_dec_hi;
            dec_valid <= 1'b1;
        end else begin
            dec_valid <= 1'b0;
        end
    end

endmodule
